// File: rtl/ysyx_22040895_lsu_pkg.sv
// Shared encodings for the ysyx_22040895 load/store unit: access sizes,
// FSM states and the default datapath width.
package ysyx_22040895_lsu_pkg;

    localparam int XLEN_DEFAULT = 64;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } size_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RESP = 2'd2,
        S_WB   = 2'd3
    } state_e;

endpackage

// File: rtl/ysyx_22040895_lsu_align.sv
// Combinational byte-lane logic: bus-aligned address, store mask/data shift,
// load extract with sign/zero extension, and the misalignment flag.
module ysyx_22040895_lsu_align
    import ysyx_22040895_lsu_pkg::*;
#(
    parameter int XLEN   = XLEN_DEFAULT,
    parameter int ADDR_W = 64
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic [1:0]        size,
    input  logic              is_store,
    input  logic              is_unsigned,
    input  logic [XLEN-1:0]   wdata,
    input  logic [XLEN-1:0]   rdata,
    output logic              misalign,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [XLEN/8-1:0] wmask,
    output logic [XLEN-1:0]   wdata_sh,
    output logic [XLEN-1:0]   load_data
);

    localparam int OFF_W = $clog2(XLEN / 8);

    logic [OFF_W-1:0]  off;
    logic [XLEN/8-1:0] base_mask;
    logic [XLEN-1:0]   shifted;
    logic              sign_bit;
    logic              ext_bit;
    int unsigned       width;

    assign off      = addr[OFF_W-1:0];
    assign mem_addr = {addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    assign wdata_sh = wdata << {off, 3'b000};
    assign shifted  = rdata >> {off, 3'b000};
    assign width    = 32'd8 << size;

    always_comb begin
        misalign = 1'b0;
        sign_bit = 1'b0;
        unique case (size)
            SZ_B: begin
                misalign = 1'b0;
                sign_bit = shifted[7];
            end
            SZ_H: begin
                misalign = addr[0];
                sign_bit = shifted[15];
            end
            SZ_W: begin
                misalign = |addr[1:0];
                sign_bit = shifted[31];
            end
            default: begin
                // A double access has no legal lane layout on a 32-bit bus.
                misalign = (XLEN == 32) || (|addr[2:0]);
                sign_bit = shifted[XLEN-1];
            end
        endcase
    end

    assign ext_bit = sign_bit & ~is_unsigned;

    always_comb begin
        base_mask = '0;
        for (int unsigned i = 0; i < XLEN / 8; i++) begin
            base_mask[i] = (i < (32'd1 << size));
        end
    end

    assign wmask = is_store ? (base_mask << off) : '0;

    always_comb begin
        load_data = '0;
        for (int unsigned i = 0; i < XLEN; i++) begin
            load_data[i] = (i < width) ? shifted[i] : ext_bit;
        end
    end

endmodule

// File: rtl/ysyx_22040895_lsu.sv
// MEM-stage load/store unit: accepts one op from EX, issues at most one
// memory request, and hands the result to WB over a valid/ready handshake.
module ysyx_22040895_lsu
    import ysyx_22040895_lsu_pkg::*;
#(
    parameter int XLEN   = XLEN_DEFAULT,
    parameter int ADDR_W = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_load,
    input  logic              in_store,
    input  logic [1:0]        in_size,
    input  logic              in_unsigned,
    input  logic [XLEN-1:0]   in_result,
    input  logic [XLEN-1:0]   in_wdata,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [XLEN/8-1:0] mem_wmask,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic              mem_rsp_valid,
    input  logic [XLEN-1:0]   mem_rdata,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [XLEN-1:0]   wb_data,
    output logic              wb_misalign
);

    state_e state, state_next;

    logic [ADDR_W-1:0] r_addr;
    logic [1:0]        r_size;
    logic              r_store;
    logic              r_unsigned;
    logic [XLEN-1:0]   r_wdata;
    logic [XLEN-1:0]   r_data;
    logic              r_misalign;

    logic              sel_idle;
    logic              in_mem;
    logic [ADDR_W-1:0] a_addr;
    logic [1:0]        a_size;
    logic              a_store;
    logic              a_unsigned;
    logic [XLEN-1:0]   a_wdata;
    logic              a_misalign;
    logic [ADDR_W-1:0] a_mem_addr;
    logic [XLEN/8-1:0] a_wmask;
    logic [XLEN-1:0]   a_wdata_sh;
    logic [XLEN-1:0]   a_load_data;

    // The single align instance sees live inputs in IDLE (for the accept
    // decision) and the captured operation in every other state.
    assign sel_idle   = (state == S_IDLE);
    assign in_mem     = in_load | in_store;
    assign a_addr     = sel_idle ? in_result[ADDR_W-1:0] : r_addr;
    assign a_size     = sel_idle ? in_size : r_size;
    assign a_store    = sel_idle ? (in_store & ~in_load) : r_store;
    assign a_unsigned = sel_idle ? in_unsigned : r_unsigned;
    assign a_wdata    = sel_idle ? in_wdata : r_wdata;

    ysyx_22040895_lsu_align #(
        .XLEN   (XLEN),
        .ADDR_W (ADDR_W)
    ) u_align (
        .addr        (a_addr),
        .size        (a_size),
        .is_store    (a_store),
        .is_unsigned (a_unsigned),
        .wdata       (a_wdata),
        .rdata       (mem_rdata),
        .misalign    (a_misalign),
        .mem_addr    (a_mem_addr),
        .wmask       (a_wmask),
        .wdata_sh    (a_wdata_sh),
        .load_data   (a_load_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            r_addr     <= '0;
            r_size     <= '0;
            r_store    <= 1'b0;
            r_unsigned <= 1'b0;
            r_wdata    <= '0;
            r_data     <= '0;
            r_misalign <= 1'b0;
        end else begin
            state <= state_next;
            unique case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_addr     <= a_addr;
                        r_size     <= a_size;
                        r_store    <= a_store;
                        r_unsigned <= a_unsigned;
                        r_wdata    <= a_wdata;
                        r_data     <= in_mem ? '0 : in_result;
                        r_misalign <= in_mem & a_misalign;
                    end
                end
                S_RESP: begin
                    if (mem_rsp_valid) begin
                        r_data <= r_store ? '0 : a_load_data;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE: begin
                if (in_valid) begin
                    state_next = (in_mem && !a_misalign) ? S_REQ : S_WB;
                end
            end
            S_REQ:  if (mem_req_ready) state_next = S_RESP;
            S_RESP: if (mem_rsp_valid) state_next = S_WB;
            S_WB:   if (wb_ready) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    assign in_ready      = sel_idle;
    assign mem_req_valid = (state == S_REQ);
    assign mem_addr      = mem_req_valid ? a_mem_addr : '0;
    assign mem_we        = mem_req_valid & r_store;
    assign mem_wmask     = mem_req_valid ? a_wmask : '0;
    assign mem_wdata     = mem_req_valid ? a_wdata_sh : '0;
    assign wb_valid      = (state == S_WB);
    assign wb_data       = r_data;
    assign wb_misalign   = wb_valid & r_misalign;

endmodule

// File: tb/tb_ysyx_22040895_lsu.sv
// Directed bench for the LSU: a 64-bit instance for the main scenarios and a
// 32-bit instance for bus-width-specific behaviour.
module tb_ysyx_22040895_lsu;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic        in_valid, in_ready, in_load, in_store, in_unsigned;
    logic [1:0]  in_size;
    logic [63:0] in_result, in_wdata;
    logic        mem_req_valid, mem_req_ready, mem_we, mem_rsp_valid;
    logic [63:0] mem_addr, mem_wdata, mem_rdata;
    logic [7:0]  mem_wmask;
    logic        wb_valid, wb_ready, wb_misalign;
    logic [63:0] wb_data;

    logic        h_in_valid, h_in_ready, h_in_load, h_in_store, h_in_unsigned;
    logic [1:0]  h_in_size;
    logic [31:0] h_in_result, h_in_wdata;
    logic        h_mem_req_valid, h_mem_req_ready, h_mem_we, h_mem_rsp_valid;
    logic [31:0] h_mem_addr, h_mem_wdata, h_mem_rdata;
    logic [3:0]  h_mem_wmask;
    logic        h_wb_valid, h_wb_ready, h_wb_misalign;
    logic [31:0] h_wb_data;

    ysyx_22040895_lsu #(.XLEN(64), .ADDR_W(64)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_load(in_load),
        .in_store(in_store), .in_size(in_size), .in_unsigned(in_unsigned),
        .in_result(in_result), .in_wdata(in_wdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wmask(mem_wmask),
        .mem_wdata(mem_wdata), .mem_rsp_valid(mem_rsp_valid),
        .mem_rdata(mem_rdata), .wb_valid(wb_valid), .wb_ready(wb_ready),
        .wb_data(wb_data), .wb_misalign(wb_misalign)
    );

    ysyx_22040895_lsu #(.XLEN(32), .ADDR_W(32)) dut32 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(h_in_valid), .in_ready(h_in_ready), .in_load(h_in_load),
        .in_store(h_in_store), .in_size(h_in_size), .in_unsigned(h_in_unsigned),
        .in_result(h_in_result), .in_wdata(h_in_wdata),
        .mem_req_valid(h_mem_req_valid), .mem_req_ready(h_mem_req_ready),
        .mem_addr(h_mem_addr), .mem_we(h_mem_we), .mem_wmask(h_mem_wmask),
        .mem_wdata(h_mem_wdata), .mem_rsp_valid(h_mem_rsp_valid),
        .mem_rdata(h_mem_rdata), .wb_valid(h_wb_valid), .wb_ready(h_wb_ready),
        .wb_data(h_wb_data), .wb_misalign(h_wb_misalign)
    );

    task automatic issue(input logic ld, input logic st, input logic [1:0] sz,
                         input logic uns, input logic [63:0] res, input logic [63:0] wd);
        in_valid = 1'b1; in_load = ld; in_store = st; in_size = sz;
        in_unsigned = uns; in_result = res; in_wdata = wd;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        tests++; if (wb_valid !== 1'b0) begin fails++; $display("FAIL reset_wb_valid got=%b exp=0", wb_valid); end
        tests++; if (mem_req_valid !== 1'b0) begin fails++; $display("FAIL reset_req_valid got=%b exp=0", mem_req_valid); end
        tests++; if ({mem_we, mem_wmask, mem_addr, mem_wdata} !== '0) begin fails++; $display("FAIL reset_mem_out got we=%b mask=%h addr=%h wdata=%h exp all 0", mem_we, mem_wmask, mem_addr, mem_wdata); end
        tests++; if ({wb_data, wb_misalign} !== '0) begin fails++; $display("FAIL reset_wb_out got data=%h mis=%b exp 0", wb_data, wb_misalign); end
        tests++; if (h_in_ready !== 1'b1) begin fails++; $display("FAIL reset32_in_ready got=%b exp=1", h_in_ready); end
    endtask

    task automatic test_passthrough();
        issue(1'b0, 1'b0, 2'd0, 1'b0, 64'h1234, 64'h0);
        tests++; if (wb_valid !== 1'b1) begin fails++; $display("FAIL pass_wb_valid got=%b exp=1", wb_valid); end
        tests++; if (wb_data !== 64'h1234) begin fails++; $display("FAIL pass_wb_data got=%h exp=%h", wb_data, 64'h1234); end
        tests++; if (mem_req_valid !== 1'b0) begin fails++; $display("FAIL pass_no_req got=%b exp=0", mem_req_valid); end
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL pass_in_ready got=%b exp=0", in_ready); end
        @(negedge clk);
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL pass_return_idle got=%b exp=1", in_ready); end
    endtask

    task automatic test_load_ext();
        logic [63:0] exp;
        for (int k = 0; k < 2; k++) begin
            exp = (k == 1) ? 64'h80 : 64'hFFFF_FFFF_FFFF_FF80;
            issue(1'b1, 1'b0, 2'd0, k[0], 64'h8000_0003, 64'h0);
            tests++; if (mem_req_valid !== 1'b1) begin fails++; $display("FAIL ld%0d_req_valid got=%b exp=1", k, mem_req_valid); end
            tests++; if (mem_addr !== 64'h8000_0000) begin fails++; $display("FAIL ld%0d_addr got=%h exp=%h", k, mem_addr, 64'h8000_0000); end
            tests++; if ({mem_we, mem_wmask} !== 9'h0) begin fails++; $display("FAIL ld%0d_we_mask got we=%b mask=%h exp 0", k, mem_we, mem_wmask); end
            mem_req_ready = 1'b1;
            if (k == 1) begin
                // Response in the request cycle must be ignored.
                mem_rsp_valid = 1'b1; mem_rdata = 64'h0000_0000_7F00_0000;
            end
            @(negedge clk);
            mem_req_ready = 1'b0;
            if (k == 1) begin
                mem_rsp_valid = 1'b0;
                @(negedge clk);
                tests++; if (wb_valid !== 1'b0) begin fails++; $display("FAIL ld_early_rsp_ignored got=%b exp=0", wb_valid); end
            end
            tests++; if (mem_req_valid !== 1'b0) begin fails++; $display("FAIL ld%0d_req_drop got=%b exp=0", k, mem_req_valid); end
            mem_rsp_valid = 1'b1; mem_rdata = 64'h0000_0000_80FF_0000;
            @(negedge clk);
            mem_rsp_valid = 1'b0;
            tests++; if (wb_valid !== 1'b1) begin fails++; $display("FAIL ld%0d_wb_valid got=%b exp=1", k, wb_valid); end
            tests++; if (wb_data !== exp) begin fails++; $display("FAIL ld%0d_wb_data got=%h exp=%h", k, wb_data, exp); end
            @(negedge clk);
        end
    endtask

    task automatic test_misalign();
        issue(1'b1, 1'b0, 2'd2, 1'b0, 64'h8000_0002, 64'h0);
        tests++; if (mem_req_valid !== 1'b0) begin fails++; $display("FAIL mis_no_req got=%b exp=0", mem_req_valid); end
        tests++; if (wb_valid !== 1'b1) begin fails++; $display("FAIL mis_wb_valid got=%b exp=1", wb_valid); end
        tests++; if (wb_misalign !== 1'b1) begin fails++; $display("FAIL mis_flag got=%b exp=1", wb_misalign); end
        tests++; if (wb_data !== 64'h0) begin fails++; $display("FAIL mis_wb_data got=%h exp=0", wb_data); end
        @(negedge clk);
        tests++; if (wb_misalign !== 1'b0) begin fails++; $display("FAIL mis_flag_clear got=%b exp=0", wb_misalign); end
    endtask

    task automatic test_store_half();
        mem_req_ready = 1'b0;
        issue(1'b0, 1'b1, 2'd1, 1'b0, 64'h8000_0006, 64'hBEEF);
        for (int c = 0; c < 3; c++) begin
            tests++; if (mem_req_valid !== 1'b1) begin fails++; $display("FAIL st_req_valid c%0d got=%b exp=1", c, mem_req_valid); end
            tests++; if (mem_we !== 1'b1) begin fails++; $display("FAIL st_we c%0d got=%b exp=1", c, mem_we); end
            tests++; if (mem_wmask !== 8'hC0) begin fails++; $display("FAIL st_wmask c%0d got=%h exp=c0", c, mem_wmask); end
            tests++; if (mem_wdata !== 64'hBEEF_0000_0000_0000) begin fails++; $display("FAIL st_wdata c%0d got=%h exp=%h", c, mem_wdata, 64'hBEEF_0000_0000_0000); end
            tests++; if (mem_addr !== 64'h8000_0000) begin fails++; $display("FAIL st_addr c%0d got=%h exp=%h", c, mem_addr, 64'h8000_0000); end
            if (c == 2) mem_req_ready = 1'b1;
            @(negedge clk);
        end
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b1; mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        tests++; if (wb_valid !== 1'b1) begin fails++; $display("FAIL st_wb_valid got=%b exp=1", wb_valid); end
        tests++; if (wb_data !== 64'h0) begin fails++; $display("FAIL st_wb_data got=%h exp=0", wb_data); end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        wb_ready = 1'b0;
        issue(1'b0, 1'b0, 2'd0, 1'b0, 64'hCAFE, 64'h0);
        in_valid = 1'b1; in_result = 64'hDEAD;
        for (int c = 0; c < 4; c++) begin
            tests++; if (wb_valid !== 1'b1) begin fails++; $display("FAIL bp_wb_valid c%0d got=%b exp=1", c, wb_valid); end
            tests++; if (wb_data !== 64'hCAFE) begin fails++; $display("FAIL bp_wb_data c%0d got=%h exp=cafe", c, wb_data); end
            tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_in_ready c%0d got=%b exp=0", c, in_ready); end
            @(negedge clk);
        end
        in_valid = 1'b0; wb_ready = 1'b1;
        @(negedge clk);
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_release got=%b exp=1", in_ready); end
    endtask

    task automatic test_reset_midop();
        issue(1'b1, 1'b0, 2'd3, 1'b0, 64'h8000_0008, 64'h0);
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL rstmid_in_ready got=%b exp=1", in_ready); end
        tests++; if (wb_valid !== 1'b0) begin fails++; $display("FAIL rstmid_wb_valid got=%b exp=0", wb_valid); end
        tests++; if (wb_data !== 64'h0) begin fails++; $display("FAIL rstmid_wb_data got=%h exp=0", wb_data); end
        @(negedge clk);
        rst_n = 1'b1;
        mem_rsp_valid = 1'b1; mem_rdata = 64'h1111_2222_3333_4444;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL stale_in_ready c%0d got=%b exp=1", c, in_ready); end
            tests++; if (wb_valid !== 1'b0) begin fails++; $display("FAIL stale_wb_valid c%0d got=%b exp=0", c, wb_valid); end
            tests++; if (wb_data !== 64'h0) begin fails++; $display("FAIL stale_wb_data c%0d got=%h exp=0", c, wb_data); end
        end
        mem_rsp_valid = 1'b0;
    endtask

    task automatic test_xlen32();
        h_in_valid = 1'b1; h_in_load = 1'b1; h_in_size = 2'd3; h_in_result = 32'h0;
        @(negedge clk);
        h_in_valid = 1'b0;
        tests++; if (h_mem_req_valid !== 1'b0) begin fails++; $display("FAIL x32_d_no_req got=%b exp=0", h_mem_req_valid); end
        tests++; if ({h_wb_valid, h_wb_misalign} !== 2'b11) begin fails++; $display("FAIL x32_d_misalign got valid=%b mis=%b exp 1 1", h_wb_valid, h_wb_misalign); end
        tests++; if (h_wb_data !== 32'h0) begin fails++; $display("FAIL x32_d_data got=%h exp=0", h_wb_data); end
        @(negedge clk);
        h_in_valid = 1'b1; h_in_size = 2'd0; h_in_result = 32'h0000_1002;
        @(negedge clk);
        h_in_valid = 1'b0;
        tests++; if (h_mem_addr !== 32'h0000_1000) begin fails++; $display("FAIL x32_b_addr got=%h exp=1000", h_mem_addr); end
        h_mem_req_ready = 1'b1;
        @(negedge clk);
        h_mem_req_ready = 1'b0;
        h_mem_rsp_valid = 1'b1; h_mem_rdata = 32'h00AB_0000;
        @(negedge clk);
        h_mem_rsp_valid = 1'b0;
        tests++; if (h_wb_data !== 32'hFFFF_FFAB) begin fails++; $display("FAIL x32_b_data got=%h exp=ffffffab", h_wb_data); end
        tests++; if (h_wb_misalign !== 1'b0) begin fails++; $display("FAIL x32_b_misalign got=%b exp=0", h_wb_misalign); end
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0; in_load = 1'b0; in_store = 1'b0; in_size = 2'd0;
        in_unsigned = 1'b0; in_result = '0; in_wdata = '0;
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rdata = '0; wb_ready = 1'b1;
        h_in_valid = 1'b0; h_in_load = 1'b0; h_in_store = 1'b0; h_in_size = 2'd0;
        h_in_unsigned = 1'b0; h_in_result = '0; h_in_wdata = '0;
        h_mem_req_ready = 1'b0; h_mem_rsp_valid = 1'b0; h_mem_rdata = '0; h_wb_ready = 1'b1;
        repeat (2) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        @(negedge clk);
        test_passthrough();
        test_load_ext();
        test_misalign();
        test_store_half();
        test_backpressure();
        test_reset_midop();
        test_xlen32();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
